// File: rtl/ibex_pext_dotp_unit.sv
// rtl/ibex_pext_dotp_unit.sv - iterative Zpn byte-lane dot-product / absolute-difference unit
package ibex_pkg_pext;
    typedef enum logic [3:0] {
        ZPN_ADD16   = 4'd0,
        ZPN_SUB16   = 4'd1,
        ZPN_SMAQA   = 4'd2,
        ZPN_SMAQAsu = 4'd3,
        ZPN_UMAQA   = 4'd4,
        ZPN_PBSAD   = 4'd5,
        ZPN_PBSADA  = 4'd6,
        ZPN_ADD8    = 4'd7
    } zpn_op_e;
endpackage

module ibex_pext_dotp_unit
    import ibex_pkg_pext::*;
#(
    parameter int LanesPerCycle = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        kill_i,
    input  zpn_op_e     zpn_operator_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    input  logic [31:0] operand_c_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] result_o
);

    generate
        if (!(LanesPerCycle == 1 || LanesPerCycle == 2 || LanesPerCycle == 4)) begin : gen_bad_lanes
            $error("LanesPerCycle must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e      state_q, state_d;
    logic [31:0] a_q, b_q, acc_q;
    zpn_op_e     op_q;
    logic [1:0]  cnt_q;
    logic        supported, start, last;
    logic [31:0] lane_sum;
    logic [1:0]  idx;

    // Both multiply flavours share one 9x9 signed multiplier; signedness is
    // chosen by extending each byte with its sign bit or with zero.
    function automatic logic [31:0] lane_term(zpn_op_e op, logic [7:0] a, logic [7:0] b);
        logic signed [8:0]  ea, eb;
        logic signed [17:0] prod;
        logic [8:0]         diff, mag;
        ea   = {((op == ZPN_SMAQA) || (op == ZPN_SMAQAsu)) & a[7], a};
        eb   = {(op == ZPN_SMAQA) & b[7], b};
        prod = ea * eb;
        diff = {1'b0, a} - {1'b0, b};
        mag  = diff[8] ? (9'd0 - diff) : diff;
        if ((op == ZPN_PBSAD) || (op == ZPN_PBSADA)) begin
            return {23'd0, mag};
        end
        return {{14{prod[17]}}, prod};
    endfunction

    assign supported = (zpn_operator_i == ZPN_SMAQA)  || (zpn_operator_i == ZPN_SMAQAsu) ||
                       (zpn_operator_i == ZPN_UMAQA)  || (zpn_operator_i == ZPN_PBSAD)   ||
                       (zpn_operator_i == ZPN_PBSADA);
    assign start     = (state_q == IDLE) && en_i && !kill_i && supported;
    assign last      = (({1'b0, cnt_q} + 3'(LanesPerCycle)) == 3'd4);

    always_comb begin
        lane_sum = '0;
        idx      = '0;
        for (int j = 0; j < LanesPerCycle; j++) begin
            idx      = cnt_q + 2'(j);
            lane_sum = lane_sum + lane_term(op_q, a_q[{idx, 3'b000} +: 8], b_q[{idx, 3'b000} +: 8]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= zpn_op_e'(4'd0);
        end else begin
            state_q <= state_d;
            if (kill_i) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else if (start) begin
                a_q   <= operand_a_i;
                b_q   <= operand_b_i;
                op_q  <= zpn_operator_i;
                acc_q <= (zpn_operator_i == ZPN_PBSAD) ? 32'd0 : operand_c_i;
                cnt_q <= '0;
            end else if (state_q == CALC) begin
                acc_q <= acc_q + lane_sum;
                cnt_q <= cnt_q + 2'(LanesPerCycle);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill_i) state_d = IDLE;
    end

    always_comb begin
        busy_o   = (state_q != IDLE);
        valid_o  = (state_q == DONE) && !kill_i;
        result_o = valid_o ? acc_q : 32'd0;
    end

endmodule

// File: tb/tb_ibex_pext_dotp_unit.sv
// tb/tb_ibex_pext_dotp_unit.sv - self-checking bench for ibex_pext_dotp_unit at 1, 2 and 4 lanes per cycle
module tb_ibex_pext_dotp_unit;
    import ibex_pkg_pext::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        kill = 1'b0;
    zpn_op_e     op = ZPN_ADD16;
    logic [31:0] a = '0, b = '0, c = '0;
    logic [2:0]  en = '0;
    logic [2:0]  busy, vld;
    logic [31:0] res [3];

    int total = 0;
    int bad = 0;
    int lat [3];
    zpn_op_e ops [5];

    always #5 clk = ~clk;

    ibex_pext_dotp_unit #(.LanesPerCycle(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en[0]), .kill_i(kill), .zpn_operator_i(op),
        .operand_a_i(a), .operand_b_i(b), .operand_c_i(c),
        .busy_o(busy[0]), .valid_o(vld[0]), .result_o(res[0]));
    ibex_pext_dotp_unit #(.LanesPerCycle(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en[1]), .kill_i(kill), .zpn_operator_i(op),
        .operand_a_i(a), .operand_b_i(b), .operand_c_i(c),
        .busy_o(busy[1]), .valid_o(vld[1]), .result_o(res[1]));
    ibex_pext_dotp_unit #(.LanesPerCycle(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en[2]), .kill_i(kill), .zpn_operator_i(op),
        .operand_a_i(a), .operand_b_i(b), .operand_c_i(c),
        .busy_o(busy[2]), .valid_o(vld[2]), .result_o(res[2]));

    // Reference: four independent byte lanes with plain integer arithmetic.
    function automatic logic [31:0] model(zpn_op_e o, logic [31:0] x, logic [31:0] y, logic [31:0] z);
        logic [31:0] sum;
        int xa, yb, term;
        sum = (o == ZPN_PBSAD) ? 32'd0 : z;
        for (int k = 0; k < 4; k++) begin
            xa = int'((x >> (8 * k)) & 32'hFF);
            yb = int'((y >> (8 * k)) & 32'hFF);
            if ((o == ZPN_SMAQA || o == ZPN_SMAQAsu) && xa > 127) xa = xa - 256;
            if (o == ZPN_SMAQA && yb > 127) yb = yb - 256;
            if (o == ZPN_PBSAD || o == ZPN_PBSADA) begin
                term = xa - yb;
                if (term < 0) term = -term;
            end else begin
                term = xa * yb;
            end
            sum = sum + 32'(term);
        end
        return sum;
    endfunction

    task automatic run_op(input zpn_op_e o, input logic [31:0] ia, input logic [31:0] ib,
                          input logic [31:0] ic, input logic [31:0] exp, input bit scramble,
                          input string name);
        bit done [3];
        op = o; a = ia; b = ib; c = ic;
        en = 3'b111;
        for (int i = 0; i < 3; i++) done[i] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                if (vld[i]) begin
                    total++;
                    if (done[i]) begin
                        bad++;
                        $display("FAIL %s dut%0d extra valid at cycle %0d result=%h", name, i, k, res[i]);
                    end else if (k != lat[i] || res[i] !== exp) begin
                        bad++;
                        $display("FAIL %s dut%0d got cycle=%0d result=%h want cycle=%0d result=%h",
                                 name, i, k, res[i], lat[i], exp);
                    end
                    done[i] = 1'b1;
                    en[i] = 1'b0;
                end else if (res[i] !== 32'd0) begin
                    total++;
                    bad++;
                    $display("FAIL %s dut%0d result_o=%h while valid low, want 0", name, i, res[i]);
                end
            end
            if (scramble) begin
                a = $urandom; b = $urandom; c = $urandom;
                op = ops[$urandom_range(0, 4)];
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (!done[i]) begin
                total++;
                bad++;
                $display("FAIL %s dut%0d timeout no valid got=0 want=1", name, i);
            end
        end
        en = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = '0; kill = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (busy[i] !== 1'b0 || vld[i] !== 1'b0 || res[i] !== 32'd0) begin
                bad++;
                $display("FAIL reset dut%0d busy=%b valid=%b result=%h want 0/0/0", i, busy[i], vld[i], res[i]);
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_op(ZPN_SMAQA,   32'h0102FF80, 32'h0203FF80, 32'h00000010, 32'h00004019, 1'b0, "smaqa");
        run_op(ZPN_SMAQAsu, 32'h000000FF, 32'h000000FF, 32'h00000000, 32'hFFFFFF01, 1'b0, "smaqasu");
        run_op(ZPN_SMAQA,   32'h000000FF, 32'h000000FF, 32'h00000000, 32'h00000001, 1'b0, "smaqa_ff");
        run_op(ZPN_UMAQA,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0003F803, 1'b0, "umaqa_wrap");
        run_op(ZPN_PBSAD,   32'h0A00FF01, 32'h050001FF, 32'hDEADBEEF, 32'h00000201, 1'b0, "pbsad");
        run_op(ZPN_PBSADA,  32'h0A00FF01, 32'h050001FF, 32'h00000100, 32'h00000301, 1'b0, "pbsada");
    endtask

    task automatic test_random();
        zpn_op_e o;
        logic [31:0] ra, rb, rc;
        for (int n = 0; n < 30; n++) begin
            o = ops[$urandom_range(0, 4)];
            ra = $urandom; rb = $urandom; rc = $urandom;
            run_op(o, ra, rb, rc, model(o, ra, rb, rc), 1'b1, "random");
        end
    endtask

    task automatic test_kill();
        op = ZPN_SMAQA; a = 32'h0102FF80; b = 32'h0203FF80; c = 32'h10;
        en = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        kill = 1'b1; en = '0;
        #1;
        total++;
        if (vld !== 3'b000 || busy[1:0] !== 2'b11) begin
            bad++;
            $display("FAIL kill_cycle valid=%b busy=%b want valid=000 busy=x11", vld, busy);
        end
        @(posedge clk); #1;
        kill = 1'b0;
        total++;
        if (busy !== 3'b000) begin
            bad++;
            $display("FAIL kill_idle busy=%b want 000", busy);
        end
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            total++;
            if (vld !== 3'b000) begin
                bad++;
                $display("FAIL kill_novalid valid=%b want 000", vld);
            end
        end
        run_op(ZPN_UMAQA, 32'h01010101, 32'h01010101, 32'h0, 32'h00000004, 1'b0, "after_kill");
    endtask

    task automatic test_unsupported();
        op = ZPN_ADD16; a = $urandom; b = $urandom; c = $urandom;
        en = 3'b111;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            total++;
            if (busy !== 3'b000 || vld !== 3'b000) begin
                bad++;
                $display("FAIL unsupported busy=%b valid=%b want 000/000", busy, vld);
            end
        end
        en = '0;
    endtask

    task automatic test_reset_mid();
        op = ZPN_UMAQA; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; c = 32'h1;
        en = 3'b011;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0; en = '0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (busy[i] !== 1'b0 || res[i] !== 32'd0 || vld[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid dut%0d busy=%b valid=%b result=%h want 0/0/0", i, busy[i], vld[i], res[i]);
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int seen [3];
        logic [31:0] exp2;
        exp2 = model(ZPN_PBSAD, 32'h0A00FF01, 32'h050001FF, 32'h12345678);
        op = ZPN_SMAQA; a = 32'h0102FF80; b = 32'h0203FF80; c = 32'h10;
        en = 3'b111;
        for (int i = 0; i < 3; i++) seen[i] = 0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                if (vld[i]) begin
                    total++;
                    if (seen[i] == 0 && (k != lat[i] || res[i] !== 32'h00004019)) begin
                        bad++;
                        $display("FAIL b2b_first dut%0d cycle=%0d result=%h want cycle=%0d result=00004019",
                                 i, k, res[i], lat[i]);
                    end else if (seen[i] == 1 && (k != 2 * lat[i] + 1 || res[i] !== exp2)) begin
                        bad++;
                        $display("FAIL b2b_second dut%0d cycle=%0d result=%h want cycle=%0d result=%h",
                                 i, k, res[i], 2 * lat[i] + 1, exp2);
                    end else if (seen[i] > 1) begin
                        bad++;
                        $display("FAIL b2b_extra dut%0d cycle=%0d result=%h want no valid", i, k, res[i]);
                    end
                    if (seen[i] == 0) begin
                        op = ZPN_PBSAD; a = 32'h0A00FF01; b = 32'h050001FF; c = 32'h12345678;
                    end else begin
                        en[i] = 1'b0;
                    end
                    seen[i]++;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (seen[i] != 2) begin
                bad++;
                $display("FAIL b2b_count dut%0d valids=%0d want 2", i, seen[i]);
            end
        end
        en = '0;
    endtask

    initial begin
        lat[0] = 5; lat[1] = 3; lat[2] = 2;
        ops[0] = ZPN_SMAQA; ops[1] = ZPN_SMAQAsu; ops[2] = ZPN_UMAQA;
        ops[3] = ZPN_PBSAD; ops[4] = ZPN_PBSADA;
        test_reset();
        test_directed();
        test_kill();
        test_unsupported();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
